// File: rtl/chess_pkg.sv
// Shared chess definitions: square encoding, piece codes, colors, the
// standard start position and the pawn promotion helper.
// Square layout (SQ_BITS = 5): bit0 occupied, bit1 color, bits4:2 piece type.
package chess_pkg;

  localparam int SQ_BITS = 5;

  typedef logic [SQ_BITS-1:0] square_t;
  typedef logic [7:0][7:0][SQ_BITS-1:0] board_t;  // [row][col]

  typedef enum logic [2:0] {
    PAWN   = 3'b000,
    KNIGHT = 3'b001,
    BISHOP = 3'b010,
    ROOK   = 3'b011,
    QUEEN  = 3'b100,
    KING   = 3'b111
  } piece_t;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  function automatic square_t make_sq(input piece_t p, input logic color);
    logic [2:0] t;
    t = p;
    return {t, color, 1'b1};
  endfunction

  function automatic piece_t back_rank(input int col);
    piece_t p;
    case (col)
      0, 7:    p = ROOK;
      1, 6:    p = KNIGHT;
      2, 5:    p = BISHOP;
      3:       p = QUEEN;
      default: p = KING;
    endcase
    return p;
  endfunction

  function automatic board_t build_start_board();
    board_t b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[0][c] = make_sq(back_rank(c), BLACK);
      b[1][c] = make_sq(PAWN, BLACK);
      b[6][c] = make_sq(PAWN, WHITE);
      b[7][c] = make_sq(back_rank(c), WHITE);
    end
    return b;
  endfunction

  localparam board_t START_BOARD = build_start_board();

  // White pawns run toward row 0, black pawns toward row 7; a pawn landing
  // on its far rank becomes a queen of the same color.
  function automatic square_t promote(input square_t sq, input logic [2:0] row);
    square_t r;
    logic [2:0] q;
    q = QUEEN;
    r = sq;
    if (sq[0] && (sq[4:2] == PAWN) &&
        (((sq[1] == WHITE) && (row == 3'd0)) ||
         ((sq[1] == BLACK) && (row == 3'd7))))
      r = {q, sq[1], 1'b1};
    return r;
  endfunction

endpackage

// File: rtl/board_state_writer_commit.sv
// move_commit: combinational move evaluation from the old squares.
// Ports:
//   src, dst     in   old source / destination squares
//   to_row       in   destination row (for promotion)
//   turn         in   side to move
//   new_src      out  value written to the source square (always empty)
//   new_dst      out  value written to the destination (promoted if needed)
//   src_own      out  source holds a piece of the side to move
//   dst_own      out  destination holds a piece of the side to move
//   king_hit     out  destination holds a king (capture ends the game)
module move_commit
  import chess_pkg::*;
(
  input  square_t    src,
  input  square_t    dst,
  input  logic [2:0] to_row,
  input  logic       turn,
  output square_t    new_src,
  output square_t    new_dst,
  output logic       src_own,
  output logic       dst_own,
  output logic       king_hit
);

  assign new_src  = '0;
  assign new_dst  = promote(src, to_row);
  assign src_own  = src[0] & (src[1] == turn);
  assign dst_own  = dst[0] & (dst[1] == turn);
  assign king_hit = dst[0] & (dst[4:2] == KING);

endmodule

// File: rtl/board_state_writer.sv
// board_state_writer: owns the 8x8 board and is its only writer.
// One move per handshake: IDLE accepts and latches coordinates, CHECK
// registers the verdict, WRITE commits, RESP emits a one-cycle response.
// Ports:
//   clk, resetN                    clock, async active-low reset
//   moveValid / moveReady          request handshake
//   fromRow/fromCol/toRow/toCol    requested move
//   checkRow/checkCol/checkToRow/checkToCol  latched move to legality logic
//   moveLegal                      verdict for the latched move
//   boardPos                       [row][col] board contents
//   turn                           side to move (0 white, 1 black)
//   moveDone / moveReject          one-cycle response pulses
//   capturedPiece                  destination contents before last commit
//   gameOver                       sticky, set when a king is captured
module board_state_writer
  import chess_pkg::*;
#(
  // Square width; the package encoding fixes this at 5.
  parameter int SQW = 5
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         moveValid,
  output logic                         moveReady,
  input  logic [2:0]                   fromRow,
  input  logic [2:0]                   fromCol,
  input  logic [2:0]                   toRow,
  input  logic [2:0]                   toCol,
  output logic [2:0]                   checkRow,
  output logic [2:0]                   checkCol,
  output logic [2:0]                   checkToRow,
  output logic [2:0]                   checkToCol,
  input  logic                         moveLegal,
  output logic [7:0][7:0][SQW-1:0]     boardPos,
  output logic                         turn,
  output logic                         moveDone,
  output logic                         moveReject,
  output logic [SQW-1:0]               capturedPiece,
  output logic                         gameOver
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]               state;
  logic                     ok;
  logic [7:0][7:0][SQW-1:0] board;

  square_t src_sq, dst_sq, new_src, new_dst;
  logic    src_own, dst_own, king_hit, same_sq, ok_next;

  assign src_sq = board[checkRow][checkCol];
  assign dst_sq = board[checkToRow][checkToCol];

  move_commit u_commit (
    .src      (src_sq),
    .dst      (dst_sq),
    .to_row   (checkToRow),
    .turn     (turn),
    .new_src  (new_src),
    .new_dst  (new_dst),
    .src_own  (src_own),
    .dst_own  (dst_own),
    .king_hit (king_hit)
  );

  assign same_sq = (checkRow == checkToRow) && (checkCol == checkToCol);
  // Own-rule filter on top of the external verdict; once the game is over
  // nothing is committed.
  assign ok_next = moveLegal & src_own & ~same_sq & ~dst_own & ~gameOver;

  assign moveReady = (state == S_IDLE);
  assign boardPos  = board;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= S_IDLE;
      ok            <= 1'b0;
      board         <= START_BOARD;
      turn          <= WHITE;
      moveDone      <= 1'b0;
      moveReject    <= 1'b0;
      capturedPiece <= '0;
      gameOver      <= 1'b0;
      checkRow      <= '0;
      checkCol      <= '0;
      checkToRow    <= '0;
      checkToCol    <= '0;
    end else begin
      moveDone   <= 1'b0;
      moveReject <= 1'b0;
      case (state)
        S_IDLE: begin
          if (moveValid) begin
            checkRow   <= fromRow;
            checkCol   <= fromCol;
            checkToRow <= toRow;
            checkToCol <= toCol;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          ok    <= ok_next;
          state <= S_WRITE;
        end
        S_WRITE: begin
          // ok excludes from==to, so the two square writes never collide.
          if (ok) begin
            board[checkRow][checkCol]     <= new_src;
            board[checkToRow][checkToCol] <= new_dst;
            capturedPiece                 <= dst_sq;
            gameOver                      <= gameOver | king_hit;
            turn                          <= ~turn;
          end
          state <= S_RESP;
        end
        default: begin
          moveDone   <= ok;
          moveReject <= ~ok;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_state_writer.sv
module tb_board_state_writer;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic moveValid = 1'b0, moveLegal = 1'b0;
  logic moveReady;
  logic [2:0] fromRow = '0, fromCol = '0, toRow = '0, toCol = '0;
  logic [2:0] checkRow, checkCol, checkToRow, checkToCol;
  logic [7:0][7:0][4:0] boardPos;
  logic turn, moveDone, moveReject, gameOver;
  logic [4:0] capturedPiece;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [4:0] mb[8][8];
  logic       m_turn, m_go;
  logic [4:0] m_cap;

  board_state_writer #(.SQW(5)) dut (
    .clk(clk), .resetN(resetN),
    .moveValid(moveValid), .moveReady(moveReady),
    .fromRow(fromRow), .fromCol(fromCol), .toRow(toRow), .toCol(toCol),
    .checkRow(checkRow), .checkCol(checkCol),
    .checkToRow(checkToRow), .checkToCol(checkToCol),
    .moveLegal(moveLegal), .boardPos(boardPos), .turn(turn),
    .moveDone(moveDone), .moveReject(moveReject),
    .capturedPiece(capturedPiece), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    int back[8] = '{3, 1, 2, 4, 7, 2, 1, 3};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[r][c] = 5'd0;
    for (int c = 0; c < 8; c++) begin
      mb[0][c] = {back[c][2:0], 1'b1, 1'b1};
      mb[1][c] = 5'b00011;
      mb[6][c] = 5'b00001;
      mb[7][c] = {back[c][2:0], 1'b0, 1'b1};
    end
    m_turn = 1'b0; m_go = 1'b0; m_cap = 5'd0;
  endtask

  // Applies the move to the model following the game rules; returns whether
  // it is committed.
  function automatic logic model_move(int fr, int fc, int tr, int tc, logic legal);
    logic [4:0] s, d, p;
    logic ok;
    s = mb[fr][fc];
    d = mb[tr][tc];
    ok = legal && s[0] && (s[1] == m_turn) && !(fr == tr && fc == tc) &&
         !(d[0] && d[1] == m_turn) && !m_go;
    if (ok) begin
      p = s;
      if (s[4:2] == 3'd0 && ((s[1] == 1'b0 && tr == 0) || (s[1] == 1'b1 && tr == 7)))
        p[4:2] = 3'd4;
      m_cap = d;
      if (d[0] && d[4:2] == 3'd7) m_go = 1'b1;
      mb[fr][fc] = 5'd0;
      mb[tr][tc] = p;
      m_turn = ~m_turn;
    end
    return ok;
  endfunction

  task automatic check_state(input string tag);
    logic [39:0] row_exp;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) row_exp[c*5 +: 5] = mb[r][c];
      chk($sformatf("%s_row%0d", tag, r), 64'(boardPos[r]), 64'(row_exp));
    end
    chk({tag, "_turn"}, 64'(turn), 64'(m_turn));
    chk({tag, "_cap"}, 64'(capturedPiece), 64'(m_cap));
    chk({tag, "_go"}, 64'(gameOver), 64'(m_go));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetN = 1'b0;
    moveValid = 1'b0;
    #3 resetN = 1'b1;
    model_reset();
  endtask

  task automatic do_move(input string tag, input int fr, input int fc,
                         input int tr, input int tc, input logic legal);
    int n;
    logic exp_ok;
    n = 0;
    @(negedge clk);
    while (!moveReady && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 64'(moveReady), 64'd1);
    fromRow = 3'(fr); fromCol = 3'(fc); toRow = 3'(tr); toCol = 3'(tc);
    moveLegal = legal;
    moveValid = 1'b1;
    @(posedge clk);  // edge N: accept
    #1;
    // keep requesting with junk coordinates: must be ignored while busy
    fromRow = 3'($urandom); fromCol = 3'($urandom);
    toRow = 3'($urandom); toCol = 3'($urandom);
    chk({tag, "_latch"}, 64'({checkRow, checkCol, checkToRow, checkToCol}),
        64'({3'(fr), 3'(fc), 3'(tr), 3'(tc)}));
    chk({tag, "_busy"}, 64'(moveReady), 64'd0);
    exp_ok = model_move(fr, fc, tr, tc, legal);
    @(posedge clk);  // N+1: verdict sampled
    @(posedge clk);  // N+2: commit
    #1;
    check_state(tag);
    chk({tag, "_nopulse"}, 64'({moveDone, moveReject}), 64'd0);
    @(posedge clk);  // N+3
    #1;
    moveValid = 1'b0;
    moveLegal = 1'b0;
    chk({tag, "_resp"}, 64'({moveDone, moveReject}), 64'({exp_ok, ~exp_ok}));
    chk({tag, "_ready_again"}, 64'(moveReady), 64'd1);
  endtask

  initial begin
    logic [2:0] fr, fc, tr, tc;
    model_reset();
    #12;
    // ---- reset state
    chk("rst_63", 64'(boardPos[6][3]), 64'h01);
    chk("rst_04", 64'(boardPos[0][4]), 64'h1f);
    chk("rst_70", 64'(boardPos[7][0]), 64'h0d);
    chk("rst_74", 64'(boardPos[7][4]), 64'h1d);
    chk("rst_33", 64'(boardPos[3][3]), 64'h00);
    chk("rst_ready", 64'(moveReady), 64'd1);
    chk("rst_pulses", 64'({moveDone, moveReject}), 64'd0);
    chk("rst_check", 64'({checkRow, checkCol, checkToRow, checkToCol}), 64'd0);
    check_state("rst");
    resetN = 1'b1;

    // ---- directed moves
    do_move("pawn_illegal", 6, 4, 5, 4, 1'b0);
    do_move("pawn_e3", 6, 4, 5, 4, 1'b1);
    chk("pawn_e3_dst", 64'(boardPos[5][4]), 64'h01);
    chk("pawn_e3_src", 64'(boardPos[6][4]), 64'h00);
    chk("pawn_e3_turn", 64'(turn), 64'd1);
    do_move("white_on_black", 6, 3, 5, 3, 1'b1);
    do_move("black_a6", 1, 0, 2, 0, 1'b1);
    do_move("black_on_white", 1, 1, 2, 1, 1'b1);
    do_move("same_sq", 6, 0, 6, 0, 1'b1);
    do_move("own_capture", 7, 0, 6, 0, 1'b1);
    do_move("empty_src", 4, 4, 3, 4, 1'b1);
    do_move("pawn_to_r1", 6, 2, 1, 2, 1'b1);
    do_move("black_a5", 2, 0, 3, 0, 1'b1);
    do_move("promo", 1, 2, 0, 1, 1'b1);
    chk("promo_queen", 64'(boardPos[0][1]), 64'h11);
    chk("promo_cap", 64'(capturedPiece), 64'h07);
    do_move("black_a4", 3, 0, 4, 0, 1'b1);
    do_move("king_cap", 0, 1, 0, 4, 1'b1);
    chk("king_go", 64'(gameOver), 64'd1);
    chk("king_cap_val", 64'(capturedPiece), 64'h1f);
    do_move("after_go", 1, 3, 2, 3, 1'b1);

    // ---- reset during WRITE
    apply_reset();
    @(negedge clk);
    fromRow = 3'd6; fromCol = 3'd4; toRow = 3'd4; toCol = 3'd4;
    moveLegal = 1'b1; moveValid = 1'b1;
    @(posedge clk);
    #1 moveValid = 1'b0;
    @(posedge clk);  // now in WRITE
    #1 resetN = 1'b0;
    #1;
    check_state("midrst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("midrst_nopulse", 64'({moveDone, moveReject}), 64'd0);
    end
    @(negedge clk) resetN = 1'b1;
    moveLegal = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("midrst_after", 64'({moveReady, moveDone, moveReject}), 64'b100);
    end
    check_state("midrst_post");

    // ---- random play against the model
    for (int i = 0; i < 80; i++) begin
      if (m_go && ($urandom % 2 == 0)) apply_reset();
      fr = 3'($urandom); fc = 3'($urandom);
      if ($urandom % 4 != 0) begin
        for (int k = 0; k < 64; k++) begin
          if (mb[fr][fc][0] && mb[fr][fc][1] == m_turn) break;
          fr = 3'($urandom); fc = 3'($urandom);
        end
      end
      tr = 3'($urandom); tc = 3'($urandom);
      do_move($sformatf("rnd%0d", i), int'(fr), int'(fc), int'(tr), int'(tc),
              1'($urandom % 5 != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/board_state_writer.md
Name: board_state_writer

Overview:
- Owns the 8x8 board register file and is the sole writer of boardPos; every piece-legality checker reads from it.
- Accepts one move request per handshake and samples the external legality verdict for that move.
- Commits the move (clear source, write destination, pawn promotion), toggles side-to-move and reports capture and king capture.

Parameters:
- SQW, 5, bits per square; bit0 occupied, bit1 color (0 white, 1 black), bits4:2 type (000 pawn, 001 knight, 010 bishop, 011 rook, 100 queen, 111 king).

Ports:
- clk  in  1  single clock, all state on posedge
- resetN  in  1  asynchronous active-low reset
- moveValid  in  1  request present
- moveReady  out  1  block can accept a request
- fromRow, fromCol, toRow, toCol  in  3 each  move coordinates; (0,0) top-left, (7,7) bottom-right
- checkRow, checkCol, checkToRow, checkToCol  out  3 each  latched move, driven to legality logic
- moveLegal  in  1  combinational verdict from the legality logic for the latched move
- boardPos  out  8x8xSQW  [row][col] board contents
- turn  out  1  side to move: 0 white, 1 black
- moveDone  out  1  one-cycle pulse: move committed
- moveReject  out  1  one-cycle pulse: move refused, board unchanged
- capturedPiece  out  SQW  destination contents before commit; held until next commit
- gameOver  out  1  sticky; set when a king is captured

Behaviour:
- Reset (async, resetN=0) loads the standard start position:
  - row 0: black R N B Q K B N R (cols 0..7); row 1: black pawns (5'b00011).
  - row 6: white pawns (5'b00001); row 7: white R N B Q K B N R.
  - Example squares: white king (7,4)=5'b11101; black king (0,4)=5'b11111.
  - Rows 2..5 = 0.
  - turn=0, moveReady=1, moveDone=0, moveReject=0, capturedPiece=0, gameOver=0, FSM=IDLE, check* = 0.
- White pawns advance toward row 0 and black pawns toward row 7, matching the pawn checker.
- FSM: IDLE -> CHECK -> WRITE -> RESP -> IDLE.
  - IDLE: moveReady=1. On moveValid&moveReady, latch the four coordinates into check* and go to CHECK. Inputs are ignored in every other state.
  - CHECK: moveReady=0; the legality logic evaluates the latched move. Register ok = moveLegal & src occupied & src color==turn & (from!=to) & !(dst occupied & dst color==turn) & !gameOver. Go to WRITE.
  - WRITE, if ok:
    - board[from] <= 0.
    - board[to] <= source piece, promoted to queen (type 100, color kept) when it is a pawn landing on row 0 (white) or row 7 (black).
    - capturedPiece <= old board[to].
    - gameOver <= 1 if old board[to] type==111 and occupied.
    - turn <= ~turn.
  - WRITE, if !ok: no register changes.
  - RESP: pulse moveDone (ok) or moveReject (!ok) for exactly one cycle; go to IDLE.
- Timing:
  - Fixed latency: accept at edge N; board, turn and capturedPiece are visible after edge N+2; response pulse is high during cycle N+3.
  - Throughput: one move per 4 cycles; next accept is possible at edge N+4.
- moveDone and moveReject are never high together.
- After gameOver=1, every request is rejected; only reset clears it.
- Reset asserted mid-operation aborts immediately: no partial write, no pulse, board returns to the start position.
- Coordinates are 3-bit unsigned; no wrap-around arithmetic inside this block. Edge and geometry checks belong to the legality logic.

Decomposition:
- Shared package chess_pkg holds:
  - typedef square_t (SQW bits), enum piece_t (PAWN..KING codes), color constants WHITE=0 / BLACK=1
  - START_BOARD constant
  - function promote(square_t, row)
- The board register array stays inside this module. One sub-module, move_commit, computes the new source/destination values and the capture/king flags combinationally from the old squares and turn.

Test Plan:
- Reset -> boardPos[6][3]=00001, [0][4]=11111, [7][0]=01101, [3][3]=0; turn=0; moveReady=1.
- White e-pawn (6,4)->(5,4), moveLegal=1 -> moveDone in cycle N+3; [6][4]=0, [5][4]=00001, turn=1, capturedPiece=0.
- Same request with moveLegal=0; then a black piece moved on white's turn -> moveReject each time, board and turn unchanged.
- White pawn preloaded at (1,2) with (0,1) holding a black knight; move (1,2)->(0,1) -> [0][1]=10001 (white queen), capturedPiece=00111.
- Capture of black king at (0,4) -> gameOver=1. A further legal-looking request -> moveReject.
- Assert resetN during WRITE of a pending move -> start position restored, no moveDone/moveReject pulse, moveReady=1 after release.
